// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control unit.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE
    } instr_class_t;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_IMEM    = 2'b10;
    localparam logic [1:0] ERR_DMEM    = 2'b11;

    function automatic logic opcode_legal(input logic [6:0] opc);
        return (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

    function automatic instr_class_t opcode_class(input logic [6:0] opc);
        case (opc)
            OPC_I:     return CLS_I;
            OPC_LOAD:  return CLS_LOAD;
            OPC_STORE: return CLS_STORE;
            default:   return CLS_R;
        endcase
    endfunction

    // Loads and stores use the ALU only to form the effective address.
    function automatic logic [1:0] alu_op_of(input instr_class_t cls);
        case (cls)
            CLS_R:   return ALU_RTYPE;
            CLS_I:   return ALU_ITYPE;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake and strobe bundle between the control FSM and the datapath/memories.
interface multicycle_ctrl_if;

    logic       start;
    logic [6:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;

    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       wb_sel;
    logic       reg_we;
    logic       busy;
    logic       err;
    logic [1:0] err_code;

    modport master (
        input  start, opcode, imem_ready, dmem_ready,
        output imem_req, ir_we, pc_we, dmem_req, dmem_we, alu_src, alu_op,
               wb_sel, reg_we, busy, err, err_code
    );

    modport slave (
        output start, opcode, imem_ready, dmem_ready,
        input  imem_req, ir_we, pc_we, dmem_req, dmem_we, alu_src, alu_op,
               wb_sel, reg_we, busy, err, err_code
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has gone unanswered; expired flags the last allowed cycle.
module mem_wait_timer #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: fetch/decode/execute/memory/write-back sequencing with timeouts.
// Define SEQ_CTRL_PERF_EN to add the cycle_cnt_o / instret_o performance counters.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    multicycle_ctrl_if.master  bus
`ifdef SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]        cycle_cnt_o,
    output logic [31:0]        instret_o
`endif
);

    state_t       state;
    state_t       next_state;
    instr_class_t cls;
    instr_class_t next_cls;
    logic         retire;
    logic         next_alu;
    logic [1:0]   err_hit;
    logic         waiting;
    logic         ready_now;
    logic         expired;

    // The counter runs only while a request is outstanding, so it is clean on every entry.
    assign waiting   = (state == ST_FETCH) || (state == ST_MEM);
    assign ready_now = (state == ST_FETCH) ? bus.imem_ready : bus.dmem_ready;

    mem_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_wait_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (!waiting || ready_now),
        .enable  (waiting && !ready_now),
        .expired (expired)
    );

    always_comb begin
        next_state = state;
        next_cls   = cls;
        retire     = 1'b0;
        err_hit    = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (bus.start) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    next_state = ST_DECODE;
                end else if (expired) begin
                    next_state = ST_ERROR;
                    err_hit    = ERR_IMEM;
                end
            end
            ST_DECODE: begin
                if (opcode_legal(bus.opcode)) begin
                    next_cls   = opcode_class(bus.opcode);
                    next_state = ST_EXEC;
                end else begin
                    next_state = ST_ERROR;
                    err_hit    = ERR_ILLEGAL;
                end
            end
            ST_EXEC: begin
                next_state = (cls == CLS_R || cls == CLS_I) ? ST_WB : ST_MEM;
            end
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    if (cls == CLS_LOAD) next_state = ST_WB;
                    else                 retire     = 1'b1;
                end else if (expired) begin
                    next_state = ST_ERROR;
                    err_hit    = ERR_DMEM;
                end
            end
            ST_WB:    retire = 1'b1;
            ST_ERROR: next_state = ST_ERROR;
            default:  next_state = ST_IDLE;
        endcase
        if (retire) next_state = bus.start ? ST_FETCH : ST_IDLE;
        next_alu = (next_state == ST_EXEC) || (next_state == ST_MEM) || (next_state == ST_WB);
    end

    // Strobes are decoded from the next state so each one is a clean register output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cls          <= CLS_R;
            bus.imem_req <= 1'b0;
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            bus.alu_src  <= 1'b0;
            bus.alu_op   <= ALU_ADD;
            bus.wb_sel   <= 1'b0;
            bus.reg_we   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_code <= ERR_NONE;
        end else begin
            state        <= next_state;
            cls          <= next_cls;
            bus.imem_req <= (next_state == ST_FETCH);
            bus.dmem_req <= (next_state == ST_MEM);
            bus.dmem_we  <= (next_state == ST_MEM) && (next_cls == CLS_STORE);
            bus.alu_src  <= next_alu && (next_cls != CLS_R);
            bus.alu_op   <= next_alu ? alu_op_of(next_cls) : ALU_ADD;
            bus.wb_sel   <= (next_state == ST_WB) && (next_cls == CLS_LOAD);
            bus.reg_we   <= (next_state == ST_WB);
            bus.busy     <= (next_state != ST_IDLE) && (next_state != ST_ERROR);
            if (err_hit != ERR_NONE) begin
                bus.err      <= 1'b1;
                bus.err_code <= err_hit;
            end
        end
    end

    // The IR and PC must load in the very cycle the fetched word is presented.
    assign bus.ir_we = bus.imem_req && bus.imem_ready;
    assign bus.pc_we = bus.imem_req && bus.imem_ready;

`ifdef SEQ_CTRL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_o <= '0;
            instret_o   <= '0;
        end else begin
            if (bus.busy) cycle_cnt_o <= cycle_cnt_o + 32'd1;
            if (retire)   instret_o   <= instret_o + 32'd1;
        end
    end
`endif

endmodule
